display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_pkg.sv | 30 +++
 rtl/seg7_decoder.sv | 15 +
 rtl/display_scan_controller.sv | 161 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg
//   Shared types and constants for the multiplexed 8-digit 7-segment scanner.
//   - NUM_DIGITS     : number of multiplexed digits
//   - seg7_t         : active-low segment pattern, bit0=a .. bit6=g
//   - disp_update_t  : one complete display image (value/enable/dp/bright,
//                      plus blink when BLINK_DISPLAY_EN is defined)
//   - HEX_SEG7       : hex nibble to active-low segment pattern table
package display_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [6:0] seg7_t;

    typedef struct packed {
`ifdef BLINK_DISPLAY_EN
        logic [NUM_DIGITS-1:0]   blink;
`endif
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   enable;
        logic [NUM_DIGITS-1:0]   dp;
        logic [3:0]              bright;
    } disp_update_t;

    // 0 1 2 3 4 5 6 7 8 9 A b C d E F, segment on = 0
    localparam seg7_t HEX_SEG7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
//   Combinational hex nibble to active-low 7-segment pattern.
//   Ports:
//     i_nibble : 4-bit hex digit
//     o_seg_n  : active-low segments, bit0=a .. bit6=g
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg7_t      o_seg_n
);

    assign o_seg_n = HEX_SEG7[i_nibble];

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexed scanner for 8 common-anode 7-segment digits with
//   PWM brightness and a frame-synchronous double-buffered update port.
//   Each digit slot is REFRESH_DIV cycles, split into 16 brightness phases.
//   Updates are taken into a pending buffer and promoted to the active
//   image only at a frame boundary, so a frame never shows mixed contents.
//   Optional feature: define BLINK_DISPLAY_EN to add per-digit blinking
//   (port upd_blink, toggling every BLINK_FRAMES frames).
//   Ports:
//     clock, reset      : rising-edge clock, synchronous active-high reset
//     upd_valid/ready   : update handshake; ready low while an update is pending
//     upd_value         : 8 hex nibbles, nibble k shown on digit k
//     upd_enable/dp     : per-digit enable and decimal point
//     upd_bright        : brightness 0..15 (lit for phases 0..bright)
//     upd_blink         : per-digit blink (BLINK_DISPLAY_EN only)
//     an_n, seg_n, dp_n : registered active-low anode/segment/dp drives
//     frame_tick        : one-cycle pulse in the cycle after the frame boundary
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_value,
    input  logic [7:0]  upd_enable,
    input  logic [7:0]  upd_dp,
    input  logic [3:0]  upd_bright,
`ifdef BLINK_DISPLAY_EN
    input  logic [7:0]  upd_blink,
`endif
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_tick
);

    if ((REFRESH_DIV % 16) != 0 || REFRESH_DIV < 32 || BLINK_FRAMES < 1) begin : g_param_check
        $error("display_scan_controller: REFRESH_DIV must be a multiple of 16 and >= 32");
    end

    localparam int               SUB_DIV  = REFRESH_DIV / 16;
    localparam int               SUB_W    = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);

    logic [SUB_W-1:0] r_sub;
    logic [3:0]       r_phase;
    logic [2:0]       r_index;
    disp_update_t     r_pend;
    disp_update_t     r_active;
    logic             r_upd_ready;
    logic             r_frame_tick;
    logic [7:0]       r_an_n;
    seg7_t            r_seg_n;
    logic             r_dp_n;

    disp_update_t     w_upd;
    logic             w_sub_end;
    logic             w_slot_end;
    logic             w_frame_end;
    logic             w_blink_hide;
    logic             w_lit;
    logic [3:0]       w_nibble;
    seg7_t            w_seg;

    assign w_upd.value  = upd_value;
    assign w_upd.enable = upd_enable;
    assign w_upd.dp     = upd_dp;
    assign w_upd.bright = upd_bright;

    assign w_sub_end   = (r_sub == SUB_LAST);
    assign w_slot_end  = w_sub_end && (r_phase == 4'hF);
    assign w_frame_end = w_slot_end && (r_index == 3'(NUM_DIGITS - 1));

`ifdef BLINK_DISPLAY_EN
    localparam int              BF_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [BF_W-1:0] r_blink_cnt;
    logic            r_blink_off;

    assign w_upd.blink  = upd_blink;
    assign w_blink_hide = r_blink_off && r_active.blink[r_index];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (w_frame_end) begin
            if (r_blink_cnt == BF_LAST) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end
`else
    assign w_blink_hide = 1'b0;
`endif

    assign w_nibble = r_active.value[{r_index, 2'b00} +: 4];
    assign w_lit    = r_active.enable[r_index] && (r_phase <= r_active.bright) && !w_blink_hide;

    seg7_decoder u_seg7_decoder (
        .i_nibble (w_nibble),
        .o_seg_n  (w_seg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sub           <= '0;
            r_phase         <= '0;
            r_index         <= '0;
            r_pend          <= '0;
            r_active        <= '0;
            r_active.bright <= 4'hF;
            r_upd_ready     <= 1'b1;
            r_frame_tick    <= 1'b0;
            r_an_n          <= 8'hFF;
            r_seg_n         <= 7'h7F;
            r_dp_n          <= 1'b1;
        end else begin
            // phase wraps 15->0 and index wraps 7->0 by natural overflow
            if (w_sub_end) begin
                r_sub   <= '0;
                r_phase <= r_phase + 4'd1;
                if (w_slot_end) begin
                    r_index <= r_index + 3'd1;
                end
            end else begin
                r_sub <= r_sub + 1'b1;
            end

            // A handshake needs ready=1, promotion needs ready=0, so the two
            // never coincide; a capture in the boundary cycle waits a frame.
            if (upd_valid && r_upd_ready) begin
                r_pend      <= w_upd;
                r_upd_ready <= 1'b0;
            end else if (w_frame_end && !r_upd_ready) begin
                r_active    <= r_pend;
                r_upd_ready <= 1'b1;
            end

            r_frame_tick <= w_frame_end;
            r_an_n       <= w_lit ? ~(8'b1 << r_index) : 8'hFF;
            r_seg_n      <= w_lit ? w_seg : 7'h7F;
            r_dp_n       <= w_lit ? ~r_active.dp[r_index] : 1'b1;
        end
    end

    assign upd_ready  = r_upd_ready;
    assign frame_tick = r_frame_tick;
    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
//   Scoreboard bench: the stimulus process pushes the expected display image
//   tagged with the frame in which it must appear; the monitor checks every
//   cycle of every frame against the image current for that frame.
module tb_display_scan_controller;

    localparam int RDIV  = 32;
    localparam int SLOT  = RDIV;
    localparam int FRAME = RDIV * 8;

    localparam logic [6:0] SEG_TB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [31:0] upd_value = '0;
    logic [7:0]  upd_enable = '0;
    logic [7:0]  upd_dp = '0;
    logic [3:0]  upd_bright = '0;
    logic [7:0]  upd_blink = '0;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    typedef struct {
        int          frame;
        logic [31:0] value;
        logic [7:0]  en;
        logic [7:0]  dp;
        logic [3:0]  bright;
    } exp_t;

    exp_t q[$];

    always #5 clock = ~clock;

    display_scan_controller #(.REFRESH_DIV(RDIV), .BLINK_FRAMES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_value  (upd_value),
        .upd_enable (upd_enable),
        .upd_dp     (upd_dp),
        .upd_bright (upd_bright),
`ifdef BLINK_DISPLAY_EN
        .upd_blink  (upd_blink),
`endif
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // drive point: 2 time units after the falling edge
    task automatic drv_cycle();
        @(negedge clock);
        #2;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            drv_cycle();
            n++;
        end while (frame_tick !== 1'b1 && n < 2 * FRAME);
        chk("wait_frame_tick", {31'b0, frame_tick}, 32'd1);
    endtask

    task automatic send(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp,
                        input logic [3:0] br);
        int   n = 0;
        exp_t e;
        upd_value  = v;
        upd_enable = en;
        upd_dp     = dp;
        upd_bright = br;
        upd_valid  = 1'b1;
        while (upd_ready !== 1'b1 && n < 2 * FRAME) begin
            drv_cycle();
            n++;
        end
        chk("ready_before_accept", {31'b0, upd_ready}, 32'd1);
        drv_cycle();
        upd_valid = 1'b0;
        chk("ready_low_after_accept", {31'b0, upd_ready}, 32'd0);
        // accepted during the current frame -> visible from the next one
        e.frame  = frame_no + 1;
        e.value  = v;
        e.en     = en;
        e.dp     = dp;
        e.bright = br;
        q.push_back(e);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_an_n", {24'b0, an_n}, 32'hFF);
        chk("rst_seg_n", {25'b0, seg_n}, 32'h7F);
        chk("rst_dp_n", {31'b0, dp_n}, 32'd1);
        chk("rst_upd_ready", {31'b0, upd_ready}, 32'd1);
        chk("rst_frame_tick", {31'b0, frame_tick}, 32'd0);
    endtask

    task automatic chk_blank(input int cycles);
        int lit = 0;
        for (int i = 0; i < cycles; i++) begin
            drv_cycle();
            if (an_n !== 8'hFF || seg_n !== 7'h7F || dp_n !== 1'b1) lit++;
        end
        chk("blank_cycles_after_reset", lit, 32'd0);
    endtask

    // monitor: output of sample i (i=0..FRAME-1 after the tick) reflects the
    // scan position digit i/SLOT, phase (i%SLOT)/2
    initial begin : monitor
        exp_t        cur;
        bit          synced;
        int          n;
        int          d;
        int          j;
        bit          lit;
        logic [16:0] act;
        logic [16:0] exp;
        cur = '{0, 32'h0, 8'h00, 8'h00, 4'hF};
        forever begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!(frame_tick === 1'b1 && reset === 1'b0) && n < 4 * FRAME);
            if (frame_tick !== 1'b1 || reset !== 1'b0) begin
                chk("monitor_sync_tick", {31'b0, frame_tick}, 32'd1);
                continue;
            end
            synced = 1'b1;
            while (synced) begin
                frame_no++;
                while (q.size() > 0 && q[0].frame <= frame_no) cur = q.pop_front();
                for (int i = 0; i < FRAME; i++) begin
                    @(negedge clock);
                    if (reset) begin
                        synced = 1'b0;
                        q.delete();
                        cur = '{0, 32'h0, 8'h00, 8'h00, 4'hF};
                        break;
                    end
                    d   = i / SLOT;
                    j   = i % SLOT;
                    lit = cur.en[d] && ((j / 2) <= int'(cur.bright));
                    exp = {lit ? ~(8'b1 << d) : 8'hFF,
                           lit ? SEG_TB[cur.value[4*d +: 4]] : 7'h7F,
                           lit ? ~cur.dp[d] : 1'b1,
                           (i == FRAME - 1)};
                    act = {an_n, seg_n, dp_n, frame_tick};
                    checks++;
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL frame %0d digit %0d cycle %0d: {an,seg,dp,tick} got %h expected %h",
                                 frame_no, d, j, act, exp);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 3; i++) begin
            drv_cycle();
            chk_reset_outputs();
        end
        reset = 1'b0;
        chk_blank(FRAME + 20);

        // full brightness, all digits
        wait_tick();
        repeat (50) drv_cycle();
        send(32'h01234567, 8'hFF, 8'h00, 4'd15);
        // held while ready is low; taken one cycle after ready returns
        send(32'h89ABCDEF, 8'hFF, 8'hAA, 4'd7);

        wait_tick();
        repeat (50) drv_cycle();
        send(32'hFEDCBA98, 8'hFF, 8'h00, 4'd3);

        wait_tick();
        repeat (50) drv_cycle();
        send(32'h0000A5C1, 8'h0F, 8'h01, 4'd15);

        // handshake exactly in the frame-boundary cycle
        wait_tick();
        repeat (FRAME - 1) drv_cycle();
        send(32'h13579BDF, 8'hF0, 8'hF0, 4'd0);

        // reset with an update pending
        wait_tick();
        wait_tick();
        repeat (50) drv_cycle();
        send(32'h77777777, 8'hFF, 8'hFF, 4'd15);
        repeat (40) drv_cycle();
        reset = 1'b1;
        drv_cycle();
        chk_reset_outputs();
        reset = 1'b0;
        chk_blank(FRAME + 20);
        wait_tick();
        wait_tick();
        drv_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
